apb_mst_iface: RTL and testbench

APB initiator that turns single-beat local command requests into APB read/write transfers and returns one response per command. It is the master-side counterpart of our APB slave interface: firmware-side or DMA-side logic drives the command port, and the APB outputs connect to the bus fabric and slave peripherals. One transfer is in flight at a time, and the block has no internal queue.

---
 rtl/apb_mst_pkg.sv | 16 +
 rtl/apb_mst_timeout.sv | 37 +++
 rtl/apb_mst_iface.sv | 113 +++++++++++
 tb/tb_apb_mst_iface.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mst_pkg.sv
// rtl/apb_mst_pkg.sv - shared state encoding and constants for the APB initiator
package apb_mst_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_mst_timeout.sv
// rtl/apb_mst_timeout.sv - ACCESS wait counter with expiry flag for the APB initiator
module apb_mst_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires in the wait cycle whose increment brings the count to TIMEOUT_CYCLES.
  assign expired_o = inc_i && (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_mst_iface.sv
// rtl/apb_mst_iface.sv - single-outstanding APB initiator; APB_MST_TIMEOUT_EN adds ACCESS timeout
module apb_mst_iface
  import apb_mst_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  apb_state_e        state_q;
  logic              psel_q, penable_q, pwrite_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
  logic              timeout_hit;

`ifdef APB_MST_TIMEOUT_EN
  apb_mst_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (pclk),
    .rst_i    (preset),
    .clr_i    (state_q == SETUP),
    .inc_i    ((state_q == ACCESS) && !pready),
    .expired_o(timeout_hit)
  );
`else
  // No timeout hardware: ACCESS waits for pready indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            paddr_q  <= cmd_addr;
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over a timeout expiring in the same cycle.
          if (pready || timeout_hit) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            if (pready) begin
              rsp_err_q   <= pslverr ? RSP_ERR : RSP_OK;
              rsp_rdata_q <= (!pwrite_q && !pslverr) ? prdata : '0;
            end else begin
              rsp_err_q   <= RSP_ERR;
              rsp_rdata_q <= '0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_mst_iface.sv
// tb/tb_apb_mst_iface.sv - scoreboard bench for apb_mst_iface (APB_MST_TIMEOUT_EN selects TIMEOUT_CYCLES=4)
module tb_apb_mst_iface;

`ifdef APB_MST_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;

  apb_mst_iface #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(clk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          w;
    logic        err;
    int          acc;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int prev_rsp = 0;
  bit prev_hold = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One command: w = ACCESS cycles with pready low before completion.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input int w, input logic e, input logic [31:0] rd,
                       input bit hold, input bit abort);
    int    guard;
    plan_t p;
    exp_t  x;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      $display("FAIL accept_wait: got cmd_ready=0 expected 1 within 200 cycles");
      $fatal(1, "command never accepted");
    end
    @(posedge clk);
    #1;
    if (prev_hold) chk("b2b_accept_cycle", 64'(cyc), 64'(prev_rsp + 1));
    p.wr = wr; p.addr = a; p.wdata = wr ? d : 32'h0; p.rd = rd;
    p.w = w; p.err = e; p.acc = cyc;
    plan_q.push_back(p);
    if (!abort) begin
      if (w >= TO) begin
        x.rdata = 32'h0; x.err = 1'b1; x.cyc = cyc + 1 + TO;
      end else begin
        x.rdata = (!wr && !e) ? rd : 32'h0; x.err = e; x.cyc = cyc + 2 + w;
      end
      exp_q.push_back(x);
      prev_rsp = x.cyc;
    end
    prev_hold = hold && !abort;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // APB slave model: answers each transfer according to its plan entry.
  initial begin
    plan_t p;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    forever begin
      @(negedge clk);
      if (psel && !penable && !preset) begin
        if (plan_q.size() == 0) begin
          chk("unplanned_setup", 64'(plan_q.size()), 64'd1);
        end else begin
          p = plan_q.pop_front();
          chk("setup_cycle", 64'(cyc), 64'(p.acc));
          chk("setup_paddr", 64'(paddr), 64'(p.addr));
          chk("setup_pwrite", 64'(pwrite), 64'(p.wr));
          chk("setup_pwdata", 64'(pwdata), 64'(p.wdata));
          chk("setup_cmd_ready", 64'(cmd_ready), 64'd0);
          for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            pready  = (k == p.w);
            pslverr = (k == p.w) ? p.err : 1'($urandom);
            prdata  = (k == p.w && !p.wr) ? p.rd : $urandom;
            @(negedge clk);
            if (!(psel && penable)) break;
            chk("access_paddr", 64'(paddr), 64'(p.addr));
            chk("access_pwdata", 64'(pwdata), 64'(p.wdata));
            chk("access_pwrite", 64'(pwrite), 64'(p.wr));
            chk("access_cmd_ready", 64'(cmd_ready), 64'd0);
            if (k == p.w) begin
              @(posedge clk);
              #1;
              break;
            end
          end
          pready = 1'b0; pslverr = 1'b0;
        end
      end
    end
  end

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(x.cyc));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(x.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(x.err));
        chk("rsp_psel_low", 64'(psel), 64'd0);
        chk("rsp_cmd_ready", 64'(cmd_ready), 64'd1);
      end
    end
  end

  initial begin
    int guard;
    bit h;
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 preset = 1'b0;
    gap(1);

    issue(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 0, 0);
    gap(3);
    issue(1'b0, 32'h2000_0010, 32'h5555_AAAA, 3, 1'b0, 32'h1234_5678, 0, 0);
    gap(3);
    issue(1'b0, 32'h3000_0008, 32'h0, 1, 1'b1, 32'hFFFF_FFFF, 0, 0);
    gap(2);
    issue(1'b1, 32'h4000_0000, 32'hA5A5_0001, 0, 1'b0, 32'h0, 1, 0);
    issue(1'b0, 32'h4000_0004, 32'h0, 2, 1'b0, 32'h0BAD_F00D, 0, 0);
    gap(2);
`ifdef APB_MST_TIMEOUT_EN
    issue(1'b0, 32'h5000_0000, 32'h0, 100, 1'b0, 32'h1111_1111, 0, 0);
    gap(2);
    issue(1'b0, 32'h5000_0004, 32'h0, TO - 1, 1'b0, 32'h2222_2222, 0, 0);
    gap(2);
    issue(1'b1, 32'h5000_0008, 32'h3333_3333, TO, 1'b0, 32'h0, 0, 0);
    gap(2);
`endif

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    gap(1);
    issue(1'b0, 32'h6000_0000, 32'h0, 30, 1'b0, 32'h7777_7777, 0, 1);
    guard = 0;
    @(negedge clk);
    while (!penable && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reached_access", 64'(penable), 64'd1);
    @(posedge clk);
    #1 preset = 1'b1;
    @(posedge clk);
    #1 preset = 1'b0;
    @(negedge clk);
    chk("abort_psel", 64'(psel), 64'd0);
    chk("abort_penable", 64'(penable), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    gap(5);

    for (int i = 0; i < 60; i++) begin
      h = (i != 59) && ($urandom_range(0, 1) == 1);
      issue(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 4)),
            ($urandom_range(0, 9) == 0), $urandom, h, 0);
      if (!h) gap(int'($urandom_range(0, 2)));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_exp_q", 64'(exp_q.size()), 64'd0);
    chk("drain_plan_q", 64'(plan_q.size()), 64'd0);
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
